issue_ctrl: RTL and testbench

- Decode/issue sequencer between fetch and the execution units.
- Holds one decoded instruction in an issue register and tracks in-flight destination registers in a 32-entry scoreboard.
- Releases the held instruction to its target unit only when RAW/WAW hazards are clear and that unit is ready.
- Serialises CSR and fence instructions, and drops held work on a pipeline flush.

---
 rtl/issue_ctrl_pkg.sv | 29 ++
 rtl/issue_ctrl_if.sv | 40 ++++
 rtl/issue_ctrl_scoreboard.sv | 34 +++
 rtl/issue_ctrl.sv | 124 ++++++++++++
 tb/tb_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types and sizes for the decode/issue sequencer.
package issue_ctrl_pkg;

  localparam int unsigned NB_UNIT = 6;
  localparam int unsigned NB_REGS = 32;
  localparam int unsigned REG_AW  = $clog2(NB_REGS);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic              rd_v;
    logic [REG_AW-1:0] rd_adr;
    logic              rs1_v;
    logic [REG_AW-1:0] rs1_adr;
    logic              rs2_v;
    logic [REG_AW-1:0] rs2_adr;
    logic [NB_UNIT-1:0] unit;
    logic              serial;
  } issue_entry_t;

  // One-hot register mask; x0 never produces a bit.
  function automatic logic [NB_REGS-1:0] reg_onehot(input logic v, input logic [REG_AW-1:0] adr);
    return (v && (adr != '0)) ? (NB_REGS'(1) << adr) : '0;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode, issue, writeback and status signals of the issue sequencer.
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;

  logic               dec_valid_i;
  logic               dec_ready_o;
  logic               dec_rd_v_i;
  logic [REG_AW-1:0]  dec_rd_adr_i;
  logic               dec_rs1_v_i;
  logic [REG_AW-1:0]  dec_rs1_adr_i;
  logic               dec_rs2_v_i;
  logic [REG_AW-1:0]  dec_rs2_adr_i;
  logic [NB_UNIT-1:0] dec_unit_i;
  logic               dec_serial_i;
  logic [NB_UNIT-1:0] unit_ready_i;
  logic               issue_valid_o;
  logic [NB_UNIT-1:0] issue_unit_o;
  logic               wb_v_i;
  logic [REG_AW-1:0]  wb_adr_i;
  logic               flush_i;
  logic               busy_o;
  logic [NB_REGS-1:0] sb_pending_o;

  // Decoder / pipeline side.
  modport master (
    output dec_valid_i, dec_rd_v_i, dec_rd_adr_i, dec_rs1_v_i, dec_rs1_adr_i,
           dec_rs2_v_i, dec_rs2_adr_i, dec_unit_i, dec_serial_i, unit_ready_i,
           wb_v_i, wb_adr_i, flush_i,
    input  dec_ready_o, issue_valid_o, issue_unit_o, busy_o, sb_pending_o
  );

  // Issue sequencer side.
  modport slave (
    input  dec_valid_i, dec_rd_v_i, dec_rd_adr_i, dec_rs1_v_i, dec_rs1_adr_i,
           dec_rs2_v_i, dec_rs2_adr_i, dec_unit_i, dec_serial_i, unit_ready_i,
           wb_v_i, wb_adr_i, flush_i,
    output dec_ready_o, issue_valid_o, issue_unit_o, busy_o, sb_pending_o
  );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-destination scoreboard: writeback clears, issue sets, set wins on collision.
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_v,
  input  logic [REG_AW-1:0]  clr_adr,
  input  logic               set_v,
  input  logic [REG_AW-1:0]  set_adr,
  output logic [NB_REGS-1:0] pending,
  output logic [NB_REGS-1:0] eff_pend
);

  logic [NB_REGS-1:0] pend_q;
  logic [NB_REGS-1:0] clr_mask;
  logic [NB_REGS-1:0] set_mask;

  // Masks for this cycle's retire and new writer.
  always_comb begin
    clr_mask = reg_onehot(clr_v, clr_adr);
    set_mask = reg_onehot(set_v, set_adr);
    eff_pend = pend_q & ~clr_mask;
  end

  // Pending vector update.
  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= eff_pend | set_mask;
  end

  assign pending = pend_q;

endmodule

// File: rtl/issue_ctrl.sv
// Decode/issue sequencer: one-entry issue register, hazard check, serialisation FSM.
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  issue_ctrl_if.slave  bus
);

  issue_state_e       state_q;
  issue_state_e       state_d;
  issue_entry_t       held_q;
  logic               held_valid_q;
  issue_entry_t       dec_entry;
  logic [NB_REGS-1:0] sb_pending;
  logic [NB_REGS-1:0] eff_pend;
  logic               raw;
  logic               waw;
  logic               unit_ok;
  logic               serial_ok;
  logic               issue_now;
  logic               dec_ready;
  logic               busy;
  logic [NB_UNIT-1:0] issue_unit;
  logic               accept;
  logic               sb_set_v;

  issue_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .clr_v    (bus.wb_v_i),
    .clr_adr  (bus.wb_adr_i),
    .set_v    (sb_set_v),
    .set_adr  (held_q.rd_adr),
    .pending  (sb_pending),
    .eff_pend (eff_pend)
  );

  // Pack the decoder fields into an entry.
  always_comb begin
    dec_entry         = '0;
    dec_entry.rd_v    = bus.dec_rd_v_i;
    dec_entry.rd_adr  = bus.dec_rd_adr_i;
    dec_entry.rs1_v   = bus.dec_rs1_v_i;
    dec_entry.rs1_adr = bus.dec_rs1_adr_i;
    dec_entry.rs2_v   = bus.dec_rs2_v_i;
    dec_entry.rs2_adr = bus.dec_rs2_adr_i;
    dec_entry.unit    = bus.dec_unit_i;
    dec_entry.serial  = bus.dec_serial_i;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: a blocked serial instruction parks in DRAIN until it issues.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (held_valid_q && held_q.serial && !issue_now && !bus.flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.flush_i || issue_now) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Hazard check, issue decision and handshake outputs.
  always_comb begin
    raw        = 1'b0;
    waw        = 1'b0;
    unit_ok    = 1'b0;
    serial_ok  = 1'b0;
    issue_now  = 1'b0;
    dec_ready  = 1'b0;
    issue_unit = '0;
    sb_set_v   = 1'b0;
    busy       = 1'b0;

    raw       = (held_q.rs1_v && eff_pend[held_q.rs1_adr]) ||
                (held_q.rs2_v && eff_pend[held_q.rs2_adr]);
    waw       = held_q.rd_v && eff_pend[held_q.rd_adr];
    unit_ok   = |(held_q.unit & bus.unit_ready_i);
    serial_ok = (eff_pend == '0);

    // A serial instruction only leaves with an empty scoreboard, from either state.
    issue_now = held_valid_q && !raw && !waw && unit_ok && !bus.flush_i &&
                (((state_q == RUN) && !held_q.serial) || serial_ok);

    // Same-cycle refill except behind a serial instruction, which costs one bubble.
    dec_ready  = !bus.flush_i && (!held_valid_q || (issue_now && !held_q.serial));
    issue_unit = issue_now ? held_q.unit : '0;
    sb_set_v   = issue_now && held_q.rd_v;
    busy       = held_valid_q || (|sb_pending);
  end

  assign accept = bus.dec_valid_i && dec_ready;

  // Issue register: flush drops, accept loads, issue empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid_q <= 1'b0;
      held_q       <= '0;
    end else if (bus.flush_i) begin
      held_valid_q <= 1'b0;
    end else if (accept) begin
      held_valid_q <= 1'b1;
      held_q       <= dec_entry;
    end else if (issue_now) begin
      held_valid_q <= 1'b0;
    end
  end

  assign bus.dec_ready_o   = dec_ready;
  assign bus.issue_valid_o = issue_now;
  assign bus.issue_unit_o  = issue_unit;
  assign bus.busy_o        = busy;
  assign bus.sb_pending_o  = sb_pending;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed vector table, reset sequence, randomized run against a model.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam logic [5:0] ALU = 6'b000001;
  localparam logic [5:0] LSU = 6'b000010;
  localparam logic [5:0] CSR = 6'b010000;
  localparam logic [5:0] ALL = 6'b111111;
  localparam logic [5:0] Z6  = 6'b000000;
  localparam int         N   = -1;

  logic clk = 1'b0;
  logic reset;

  issue_ctrl_if bus();

  issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         dv;
    issue_entry_t ent;
    logic [5:0]   urdy;
    logic         wbv;
    logic [4:0]   wba;
    logic         flush;
    logic         e_ready;
    logic         e_iv;
    logic [5:0]   e_iu;
    logic         e_busy;
    logic [31:0]  e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] P(input int r);
    return 32'(1) << r;
  endfunction

  // Build one vector; -1 marks an absent register operand or writeback.
  function automatic vec_t v(input logic dv, input int rd, input int rs1, input int rs2,
                             input logic [5:0] unit, input logic ser, input logic [5:0] urdy,
                             input int wb, input logic fl, input logic er, input logic ei,
                             input logic [5:0] eiu, input logic eb, input logic [31:0] ep);
    vec_t t;
    t.dv          = dv;
    t.ent.rd_v    = (rd >= 0);
    t.ent.rd_adr  = (rd >= 0) ? 5'(rd) : 5'd0;
    t.ent.rs1_v   = (rs1 >= 0);
    t.ent.rs1_adr = (rs1 >= 0) ? 5'(rs1) : 5'd0;
    t.ent.rs2_v   = (rs2 >= 0);
    t.ent.rs2_adr = (rs2 >= 0) ? 5'(rs2) : 5'd0;
    t.ent.unit    = unit;
    t.ent.serial  = ser;
    t.urdy        = urdy;
    t.wbv         = (wb >= 0);
    t.wba         = (wb >= 0) ? 5'(wb) : 5'd0;
    t.flush       = fl;
    t.e_ready     = er;
    t.e_iv        = ei;
    t.e_iu        = eiu;
    t.e_busy      = eb;
    t.e_pend      = ep;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input issue_entry_t e, input logic [5:0] urdy,
                       input logic wbv, input logic [4:0] wba, input logic fl);
    bus.dec_valid_i   = dv;
    bus.dec_rd_v_i    = e.rd_v;
    bus.dec_rd_adr_i  = e.rd_adr;
    bus.dec_rs1_v_i   = e.rs1_v;
    bus.dec_rs1_adr_i = e.rs1_adr;
    bus.dec_rs2_v_i   = e.rs2_v;
    bus.dec_rs2_adr_i = e.rs2_adr;
    bus.dec_unit_i    = e.unit;
    bus.dec_serial_i  = e.serial;
    bus.unit_ready_i  = urdy;
    bus.wb_v_i        = wbv;
    bus.wb_adr_i      = wba;
    bus.flush_i       = fl;
  endtask

  task automatic chk_outs(input string tag, input logic er, input logic ei, input logic [5:0] eiu,
                          input logic eb, input logic [31:0] ep);
    chk({tag, ".ready"}, 32'(bus.dec_ready_o), 32'(er));
    chk({tag, ".issue_valid"}, 32'(bus.issue_valid_o), 32'(ei));
    chk({tag, ".issue_unit"}, 32'(bus.issue_unit_o), 32'(eiu));
    chk({tag, ".busy"}, 32'(bus.busy_o), 32'(eb));
    chk({tag, ".pending"}, bus.sb_pending_o, ep);
  endtask

  // Reference model state: held instruction and list of in-flight destinations.
  logic         m_hv;
  issue_entry_t m_held;
  int           infl[$];

  function automatic bit in_fl(input int r);
    foreach (infl[k]) if (infl[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    issue_entry_t idle_e;
    vec_t         t;
    idle_e = '0;

    // Directed table: RAW bypass, backpressure, CSR drain, flush, set/clear collision, x0.
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 1,0,Z6,0,0));
    vecs.push_back(v(1,5,1,2,ALU,0,ALL,N,0, 1,0,Z6,0,0));
    vecs.push_back(v(1,6,5,1,ALU,0,ALL,N,0, 1,1,ALU,1,0));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 0,0,Z6,1,P(5)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,5,0, 1,1,ALU,1,P(5)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,6,0, 1,0,Z6,1,P(6)));
    vecs.push_back(v(1,7,1,N,LSU,0,ALL,N,0, 1,0,Z6,0,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(v(1,8,1,2,ALU,0,6'b111101,N,0, 0,0,Z6,1,0));
    vecs.push_back(v(1,8,1,2,ALU,0,ALL,N,0, 1,1,LSU,1,0));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 1,1,ALU,1,P(7)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,7,0, 1,0,Z6,1,P(7)|P(8)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,8,0, 1,0,Z6,1,P(8)));
    vecs.push_back(v(1,3,1,2,ALU,0,ALL,N,0, 1,0,Z6,0,0));
    vecs.push_back(v(1,4,1,N,CSR,1,ALL,N,0, 1,1,ALU,1,0));
    vecs.push_back(v(1,10,1,2,ALU,0,ALL,N,0, 0,0,Z6,1,P(3)));
    vecs.push_back(v(1,10,1,2,ALU,0,ALL,N,0, 0,0,Z6,1,P(3)));
    vecs.push_back(v(1,10,1,2,ALU,0,ALL,3,0, 0,1,CSR,1,P(3)));
    vecs.push_back(v(1,10,1,2,ALU,0,ALL,N,0, 1,0,Z6,1,P(4)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 1,1,ALU,1,P(4)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,4,0, 1,0,Z6,1,P(4)|P(10)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,10,0, 1,0,Z6,1,P(10)));
    vecs.push_back(v(1,11,N,N,CSR,1,ALL,N,0, 1,0,Z6,0,0));
    vecs.push_back(v(1,12,11,N,ALU,0,ALL,N,0, 0,1,CSR,1,0));
    vecs.push_back(v(1,12,11,N,ALU,0,ALL,N,0, 1,0,Z6,1,P(11)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 0,0,Z6,1,P(11)));
    vecs.push_back(v(1,13,1,N,ALU,0,ALL,N,1, 0,0,Z6,1,P(11)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 1,0,Z6,1,P(11)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,11,0, 1,0,Z6,1,P(11)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 1,0,Z6,0,0));
    vecs.push_back(v(1,9,1,N,ALU,0,ALL,N,0, 1,0,Z6,0,0));
    vecs.push_back(v(1,9,2,N,ALU,0,ALL,N,0, 1,1,ALU,1,0));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,9,0, 1,1,ALU,1,P(9)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 1,0,Z6,1,P(9)));
    vecs.push_back(v(1,0,1,N,ALU,0,ALL,9,0, 1,0,Z6,1,P(9)));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,N,0, 1,1,ALU,1,0));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,20,0, 1,0,Z6,0,0));
    vecs.push_back(v(0,N,N,N,Z6,0,ALL,0,0, 1,0,Z6,0,0));

    reset = 1'b1;
    drive(1'b0, idle_e, ALL, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      t = vecs[i];
      drive(t.dv, t.ent, t.urdy, t.wbv, t.wba, t.flush);
      #1;
      chk_outs($sformatf("vec%0d", i), t.e_ready, t.e_iv, t.e_iu, t.e_busy, t.e_pend);
    end

    // Reset in the middle of work: a held RAW-blocked instruction and a pending bit.
    @(negedge clk);
    drive(1'b1, v(1,14,1,N,ALU,0,ALL,N,0,0,0,Z6,0,0).ent, ALL, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, v(1,15,14,N,ALU,0,ALL,N,0,0,0,Z6,0,0).ent, ALL, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, idle_e, ALL, 1'b0, 5'd0, 1'b0);
    #1;
    chk_outs("pre_reset", 1'b0, 1'b0, Z6, 1'b1, P(14));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_outs("post_reset", 1'b1, 1'b0, Z6, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b0, idle_e, ALL, 1'b1, 5'd14, 1'b0);
    #1;
    chk_outs("stale_wb", 1'b1, 1'b0, Z6, 1'b0, 32'd0);

    // Randomized run against the model; state is empty at this point.
    m_hv   = 1'b0;
    m_held = '0;
    infl.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic         dv, wbv, fl, issue, ready, empty, hz;
      issue_entry_t e;
      logic [5:0]   urdy;
      logic [4:0]   wba;
      logic [31:0]  pv;
      int           wb_i;

      @(negedge clk);
      dv        = ($urandom_range(0, 9) < 7);
      e.rd_v    = ($urandom_range(0, 3) != 0);
      e.rd_adr  = 5'($urandom_range(0, 7));
      e.rs1_v   = $urandom_range(0, 1) == 1;
      e.rs1_adr = 5'($urandom_range(0, 7));
      e.rs2_v   = $urandom_range(0, 1) == 1;
      e.rs2_adr = 5'($urandom_range(0, 7));
      e.unit    = 6'(1) << $urandom_range(0, 5);
      e.serial  = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < 6; b++) urdy[b] = ($urandom_range(0, 3) != 0);
      wbv = ($urandom_range(0, 1) == 1);
      if (infl.size() > 0 && $urandom_range(0, 4) != 0)
        wba = 5'(infl[$urandom_range(0, infl.size() - 1)]);
      else
        wba = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 19) == 0);
      drive(dv, e, urdy, wbv, wba, fl);
      #1;

      // Model: a register is effectively pending if in flight and not retiring now.
      wb_i  = wbv ? int'(wba) : -1;
      empty = 1'b1;
      foreach (infl[k]) if (infl[k] != wb_i) empty = 1'b0;
      hz = (m_held.rs1_v && m_held.rs1_adr != 0 && in_fl(int'(m_held.rs1_adr)) && int'(m_held.rs1_adr) != wb_i) ||
           (m_held.rs2_v && m_held.rs2_adr != 0 && in_fl(int'(m_held.rs2_adr)) && int'(m_held.rs2_adr) != wb_i) ||
           (m_held.rd_v  && m_held.rd_adr  != 0 && in_fl(int'(m_held.rd_adr))  && int'(m_held.rd_adr)  != wb_i);
      issue = m_hv && !hz && ((m_held.unit & urdy) != 0) && !fl && (!m_held.serial || empty);
      ready = !fl && (!m_hv || (issue && !m_held.serial));
      pv = '0;
      foreach (infl[k]) pv[infl[k]] = 1'b1;

      chk_outs($sformatf("rnd%0d", cyc), ready, issue, issue ? m_held.unit : Z6,
               m_hv || (infl.size() > 0), pv);

      // Model update at the edge: retire first, then the new writer.
      if (wbv)
        for (int k = infl.size() - 1; k >= 0; k--)
          if (infl[k] == wb_i) infl.delete(k);
      if (issue && m_held.rd_v && m_held.rd_adr != 0 && !in_fl(int'(m_held.rd_adr)))
        infl.push_back(int'(m_held.rd_adr));
      if (fl)                 m_hv = 1'b0;
      else if (dv && ready) begin m_hv = 1'b1; m_held = e; end
      else if (issue)         m_hv = 1'b0;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
